// File: rtl/pixel_stream_source_if.sv
// AXI-Stream link between the frame replay source and its sink.
// With PIXEL_SRC_SOF_EN defined the link also carries a start-of-pass tuser bit.
interface pixel_stream_source_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
`ifdef PIXEL_SRC_SOF_EN
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
`else
    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
`endif
endinterface

// File: rtl/pixel_stream_source.sv
// Replays a stored grayscale frame NUM_PASSES times as an AXI-Stream master.
// Optional macro PIXEL_SRC_SOF_EN adds a start-of-pass tuser bit to the stream.
module pixel_stream_source #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 16,
    parameter int NUM_PASSES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_we,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     start,
    input  logic [31:0]              T_TOTAL_PIXELS,
    pixel_stream_source_if.master    m_axis,
    output logic [3:0]               pass_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    localparam int              CW          = ADDR_W + 1;
    localparam int              MEM_DEPTH   = 2 ** ADDR_W;
    localparam logic [32:0]     MEM_DEPTH_L = 33'd1 << ADDR_W;
    localparam logic [CW-1:0]   ONE_C       = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CW-1:0]   ZERO_C      = {CW{1'b0}};
    localparam logic [3:0]      LAST_PASS   = 4'(NUM_PASSES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t state_r;
    state_t state_n;

    logic [DATA_W-1:0] mem_r [0:MEM_DEPTH-1];

    logic [CW-1:0]     len_r;
    logic [CW-1:0]     rd_addr_r;
    logic [3:0]        iss_pass_r;
    logic              iss_done_r;
    logic              rd_vld_r;
    logic              rd_last_r;
    logic [DATA_W-1:0] rd_data_r;

    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_last_r;
    logic              skid_valid_r;
    logic [DATA_W-1:0] skid_data_r;
    logic              skid_last_r;

`ifdef PIXEL_SRC_SOF_EN
    logic              rd_user_r;
    logic              out_user_r;
    logic              skid_user_r;
`endif

    logic [CW-1:0]     beat_cnt_r;
    logic [3:0]        pass_r;
    logic              busy_r;
    logic              done_r;
    logic              cfg_err_r;

    logic              len_ok_s;
    logic              start_ok_s;
    logic              pop_s;
    logic [1:0]        occ_s;
    logic              issue_s;
    logic [CW-1:0]     last_idx_s;
    logic              iss_last_s;
    logic              acc_last_s;
    logic              final_acc_s;

    // Handshake, credit and terminal-count decode shared by the sequential blocks.
    always_comb begin
        len_ok_s    = (T_TOTAL_PIXELS != 32'd0) && ({1'b0, T_TOTAL_PIXELS} <= MEM_DEPTH_L);
        start_ok_s  = (state_r == ST_IDLE) && start && len_ok_s;
        pop_s       = out_valid_r && m_axis.tready;
        // Occupancy counts the read in flight so the 2-entry buffer never overflows.
        occ_s       = {1'b0, out_valid_r} + {1'b0, skid_valid_r} + {1'b0, rd_vld_r};
        last_idx_s  = len_r - ONE_C;
        iss_last_s  = (rd_addr_r == last_idx_s);
        acc_last_s  = pop_s && (beat_cnt_r == last_idx_s);
        final_acc_s = acc_last_s && (pass_r == LAST_PASS);
        if (((state_r == ST_PRIME) || (state_r == ST_STREAM)) && !iss_done_r) begin
            issue_s = (occ_s < 2'd2) || (pop_s && (occ_s == 2'd2));
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state logic of the transmit sequencer.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_n = ST_PRIME;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_PRIME:  state_n = ST_STREAM;
            ST_STREAM: begin
                if (final_acc_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_STREAM;
                end
            end
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Frame buffer: load port is locked out during transmission; contents survive reset.
    always_ff @(posedge clk) begin
        if (load_we && !busy_r) begin
            mem_r[load_addr] <= load_data;
        end
        if (issue_s) begin
            rd_data_r <= mem_r[rd_addr_r[ADDR_W-1:0]];
        end
    end

    // Read issue side: walks the buffer NUM_PASSES times, tagging each read with its stream flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r      <= ZERO_C;
            rd_addr_r  <= ZERO_C;
            iss_pass_r <= 4'd0;
            iss_done_r <= 1'b0;
            rd_vld_r   <= 1'b0;
            rd_last_r  <= 1'b0;
`ifdef PIXEL_SRC_SOF_EN
            rd_user_r  <= 1'b0;
`endif
        end else if (start_ok_s) begin
            len_r      <= T_TOTAL_PIXELS[CW-1:0];
            rd_addr_r  <= ZERO_C;
            iss_pass_r <= 4'd0;
            iss_done_r <= 1'b0;
            rd_vld_r   <= 1'b0;
        end else begin
            rd_vld_r <= issue_s;
            if (issue_s) begin
                rd_last_r <= iss_last_s;
`ifdef PIXEL_SRC_SOF_EN
                rd_user_r <= (rd_addr_r == ZERO_C);
`endif
                if (iss_last_s) begin
                    rd_addr_r <= ZERO_C;
                    if (iss_pass_r == LAST_PASS) begin
                        iss_done_r <= 1'b1;
                    end else begin
                        iss_pass_r <= iss_pass_r + 4'd1;
                    end
                end else begin
                    rd_addr_r <= rd_addr_r + ONE_C;
                end
            end
        end
    end

    // Output register plus skid entry; the head only moves when empty or accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_W{1'b0}};
            out_last_r   <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= {DATA_W{1'b0}};
            skid_last_r  <= 1'b0;
`ifdef PIXEL_SRC_SOF_EN
            out_user_r   <= 1'b0;
            skid_user_r  <= 1'b0;
`endif
        end else if (pop_s || !out_valid_r) begin
            if (skid_valid_r) begin
                out_valid_r  <= 1'b1;
                out_data_r   <= skid_data_r;
                out_last_r   <= skid_last_r;
`ifdef PIXEL_SRC_SOF_EN
                out_user_r   <= skid_user_r;
                skid_user_r  <= rd_user_r;
`endif
                skid_valid_r <= rd_vld_r;
                skid_data_r  <= rd_data_r;
                skid_last_r  <= rd_last_r;
            end else if (rd_vld_r) begin
                out_valid_r  <= 1'b1;
                out_data_r   <= rd_data_r;
                out_last_r   <= rd_last_r;
`ifdef PIXEL_SRC_SOF_EN
                out_user_r   <= rd_user_r;
`endif
            end else begin
                out_valid_r  <= 1'b0;
            end
        end else if (rd_vld_r) begin
            skid_valid_r <= 1'b1;
            skid_data_r  <= rd_data_r;
            skid_last_r  <= rd_last_r;
`ifdef PIXEL_SRC_SOF_EN
            skid_user_r  <= rd_user_r;
`endif
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end

    // Accept side: beat/pass tracking and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_r <= ZERO_C;
            pass_r     <= 4'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cfg_err_r  <= 1'b0;
        end else begin
            busy_r    <= (state_n == ST_PRIME) || (state_n == ST_STREAM);
            done_r    <= final_acc_s;
            cfg_err_r <= (state_r == ST_IDLE) && start && !len_ok_s;
            if (start_ok_s) begin
                beat_cnt_r <= ZERO_C;
                pass_r     <= 4'd0;
            end else if (acc_last_s) begin
                beat_cnt_r <= ZERO_C;
                if (pass_r != LAST_PASS) begin
                    pass_r <= pass_r + 4'd1;
                end else begin
                    pass_r <= pass_r;
                end
            end else if (pop_s) begin
                beat_cnt_r <= beat_cnt_r + ONE_C;
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
        end
    end

    assign m_axis.tvalid = out_valid_r;
    assign m_axis.tdata  = out_data_r;
    assign m_axis.tlast  = out_last_r;
`ifdef PIXEL_SRC_SOF_EN
    assign m_axis.tuser  = out_user_r;
`endif
    assign pass_idx      = pass_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign cfg_err       = cfg_err_r;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Randomized bench for pixel_stream_source: an expected-beat queue built from the
// stored frame is compared against every accepted beat, plus directed corner cases.
module tb_pixel_stream_source;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int NP     = 2;

    logic              clk;
    logic              reset;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              start;
    logic [31:0]       total_pixels;
    logic [3:0]        pass_idx;
    logic              busy;
    logic              done;
    logic              cfg_err;

    pixel_stream_source_if #(.DATA_W(DATA_W)) axis ();

    pixel_stream_source #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PASSES(NP)) dut (
        .clk            (clk),
        .reset          (reset),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .start          (start),
        .T_TOTAL_PIXELS (total_pixels),
        .m_axis         (axis),
        .pass_idx       (pass_idx),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [3:0] pass;
        logic       user;
    } beat_t;

    beat_t      exp_q [$];
    logic [7:0] frame [0:63];
    logic [7:0] acc_data [0:255];
    logic       acc_last [0:255];
    logic [3:0] acc_pass [0:255];
    int         acc_cnt;
    int         checks;
    int         errors;
    bit         chk_en;
    bit         hold_chk;
    logic [7:0] hold_data;
    logic       hold_last;
    bit         done_due;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: every accepted beat against the model, plus stall stability and done timing.
    always @(negedge clk) begin
        beat_t e;
        if (chk_en) begin
            if (hold_chk) begin
                check("stall_tvalid", axis.tvalid, 1);
                check("stall_tdata", axis.tdata, hold_data);
                check("stall_tlast", axis.tlast, hold_last);
            end
            check("done_pulse", done, done_due);
            if (done_due) check("busy_after_done", busy, 0);
            done_due = 1'b0;
            if (axis.tvalid && axis.tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_tdata", axis.tdata, e.data);
                    check("beat_tlast", axis.tlast, e.last);
                    check("beat_pass_idx", pass_idx, e.pass);
`ifdef PIXEL_SRC_SOF_EN
                    check("beat_tuser", axis.tuser, e.user);
`endif
                    if (acc_cnt < 256) begin
                        acc_data[acc_cnt] = axis.tdata;
                        acc_last[acc_cnt] = axis.tlast;
                        acc_pass[acc_cnt] = pass_idx;
                    end
                    acc_cnt++;
                    if (exp_q.size() == 0) done_due = 1'b1;
                end
            end
            hold_chk  = axis.tvalid && !axis.tready;
            hold_data = axis.tdata;
            hold_last = axis.tlast;
        end else begin
            hold_chk = 1'b0;
            done_due = 1'b0;
        end
    end

    // mode 0: ramp, 1: random, 2: constant 0xA5
    task automatic load_frame(input int len, input int mode);
        for (int i = 0; i < len; i++) begin
            frame[i] = (mode == 0) ? 8'(i) : (mode == 1) ? 8'($urandom_range(0, 255)) : 8'hA5;
            tick();
            load_we   = 1'b1;
            load_addr = 16'(i);
            load_data = frame[i];
        end
    endtask

    task automatic build_model(input int len);
        exp_q.delete();
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back('{data: frame[i], last: (i == len - 1), pass: 4'(p), user: (i == 0)});
            end
        end
        acc_cnt = 0;
    endtask

    task automatic run(input int len, input bit rand_ready, input bit poke,
                       output int cyc_done, output int first_v);
        build_model(len);
        tick();
        load_we      = 1'b0;
        start        = 1'b1;
        total_pixels = 32'(len);
        axis.tready  = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        first_v  = -1;
        cyc_done = -1;
        for (int c = 0; c < 4000; c++) begin
            if (axis.tvalid && first_v < 0) first_v = c;
            if (done) begin
                cyc_done = c;
                break;
            end
            if (poke && c == 6) check("start_while_busy_cfg_err", cfg_err, 0);
            if (poke && c == 5) begin
                start        = 1'b1;
                total_pixels = 32'd0;
                load_we      = 1'b1;
                load_addr    = 16'd0;
                load_data    = 8'hFF;
            end else begin
                start   = 1'b0;
                load_we = 1'b0;
            end
            axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        start   = 1'b0;
        load_we = 1'b0;
        check("run_finished", (cyc_done >= 0), 1);
        check("queue_drained", exp_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic bad_start(input logic [31:0] len);
        tick();
        start        = 1'b1;
        total_pixels = len;
        tick();
        start = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        check("cfg_err_tvalid", axis.tvalid, 0);
        tick();
        check("cfg_err_one_cycle", cfg_err, 0);
        check("cfg_err_busy_later", busy, 0);
        check("cfg_err_tvalid_later", axis.tvalid, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tvalid"}, axis.tvalid, 0);
        check({tag, "_tlast"}, axis.tlast, 0);
        check({tag, "_tdata"}, axis.tdata, 0);
        check({tag, "_pass_idx"}, pass_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    initial begin
        int cyc;
        int fv;
        int nlast;
        checks       = 0;
        errors       = 0;
        chk_en       = 1'b0;
        hold_chk     = 1'b0;
        done_due     = 1'b0;
        acc_cnt      = 0;
        reset        = 1'b1;
        load_we      = 1'b0;
        load_addr    = '0;
        load_data    = '0;
        start        = 1'b0;
        total_pixels = 32'd0;
        axis.tready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_state("reset");
        chk_en = 1'b1;

        // Ramp frame, full throughput, with a start and a write poked mid-run.
        load_frame(16, 0);
        run(16, 1'b0, 1'b1, cyc, fv);
        check("first_tvalid_latency", fv, 2);
        check("done_latency_full_rate", cyc, 34);
        check("ramp_beat_count", acc_cnt, 32);
        check("ramp_beat15_data", acc_data[15], 8'd15);
        check("ramp_beat15_last", acc_last[15], 1);
        check("ramp_beat16_data", acc_data[16], 8'd0);
        check("ramp_beat16_pass", acc_pass[16], 4'd1);
        check("ramp_beat31_data", acc_data[31], 8'd15);
        nlast = 0;
        for (int i = 0; i < 32; i++) nlast += int'(acc_last[i]);
        check("ramp_tlast_count", nlast, 2);

        // Same frame with random backpressure.
        run(16, 1'b1, 1'b0, cyc, fv);
        check("stalled_beat_count", acc_cnt, 32);
        check("stalled_not_faster", (cyc >= 34), 1);

        // Single-pixel frame.
        load_frame(1, 2);
        run(1, 1'b0, 1'b0, cyc, fv);
        check("len1_done_latency", cyc, 4);
        check("len1_beat0_data", acc_data[0], 8'hA5);
        check("len1_beat1_data", acc_data[1], 8'hA5);
        check("len1_beat0_last", acc_last[0], 1);
        check("len1_beat1_last", acc_last[1], 1);
        check("len1_beat0_pass", acc_pass[0], 4'd0);
        check("len1_beat1_pass", acc_pass[1], 4'd1);

        // Rejected lengths.
        bad_start(32'd0);
        bad_start(32'd65537);
        bad_start(32'hFFFF_FFFF);

        // Largest legal length is accepted, then aborted by reset.
        chk_en = 1'b0;
        tick();
        start        = 1'b1;
        total_pixels = 32'd65536;
        tick();
        start = 1'b0;
        check("max_len_busy", busy, 1);
        check("max_len_no_cfg_err", cfg_err, 0);
        tick();
        tick();
        check("max_len_tvalid", axis.tvalid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("max_len_abort");

        // Reset while beat 7 of pass 0 is on the bus, then a clean replay.
        load_frame(16, 1);
        build_model(16);
        chk_en = 1'b1;
        tick();
        load_we      = 1'b0;
        start        = 1'b1;
        total_pixels = 32'd16;
        axis.tready  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 100 && acc_cnt < 7; c++) tick();
        check("abort_reached_beat7", acc_cnt, 7);
        chk_en = 1'b0;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("mid_stream_reset");
        chk_en = 1'b1;
        run(16, 1'b1, 1'b0, cyc, fv);
        check("replay_beat_count", acc_cnt, 32);

        // Random lengths, data and backpressure.
        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(1, 40);
            load_frame(len, 1);
            run(len, 1'b1, 1'b0, cyc, fv);
            check("random_beat_count", acc_cnt, 2 * len);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_stream_source.md
# pixel_stream_source

AXI-Stream master that replays a stored 8-bit grayscale frame into the equalization datapath's slave stream. A frame is loaded once into an internal buffer through a simple write port. After `start`, the block transmits the whole frame `NUM_PASSES` times (histogram pass, then remap pass), with TLAST on the final pixel of each pass. It is the DMA-side transmitter that feeds the equalizer controller in simulation and in DMA-less builds.

## Interface
- `DATA_W`, 8, pixel width
- `ADDR_W`, 16, buffer address width; depth `MEM_DEPTH = 2**ADDR_W`
- `NUM_PASSES`, 2, passes per start, 1..15

- `clk` in 1: single clock; one clock domain, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `load_we` in 1: buffer write strobe, ignored while `busy`
- `load_addr` in ADDR_W: buffer write address
- `load_data` in DATA_W: buffer write data
- `start` in 1: begin transmission, sampled only in IDLE
- `T_TOTAL_PIXELS` in 32: frame length, latched on accepted `start`
- `m_axis_tdata` out DATA_W: pixel
- `m_axis_tvalid` out 1: beat valid
- `m_axis_tready` in 1: sink ready
- `m_axis_tlast` out 1: last pixel of current pass
- `pass_idx` out 4: current pass, 0-based
- `busy` out 1: high from accepted `start` until last beat accepted
- `done` out 1: one-cycle pulse after the final beat of the final pass
- `cfg_err` out 1: one-cycle pulse on a rejected `start`

## Operation
- Buffer: `MEM_DEPTH`×`DATA_W`, one write port and one synchronous read port with 1-cycle latency. Contents are not cleared by reset.
- States:
  - IDLE: `start` with `1 <= T_TOTAL_PIXELS <= MEM_DEPTH` → PRIME; latch length, `rd_addr=0`, `pass_idx=0`. Any other length → `cfg_err` pulse, stay in IDLE.
  - PRIME: issue read of address 0 → STREAM.
  - STREAM: beat accepted when `m_axis_tvalid && m_axis_tready`. Beat count runs 0..len-1.
    - Accept of beat len-1 with `pass_idx < NUM_PASSES-1`: `pass_idx++`, count and `rd_addr` wrap to 0, next beat is pixel 0 with no bubble.
    - Accept of beat len-1 on the final pass → DONE.
  - DONE: `done` pulse, `busy` low → IDLE.
- Prefetch: a 2-entry output FIFO decouples read latency. Reads are issued only when the FIFO will have room, so no data is lost under any `m_axis_tready` pattern.
- AXI rules:
  - `tvalid` is never withdrawn before accept.
  - `tdata`, `tlast` and `tuser` are stable while `tvalid && !tready`.
  - `tvalid` does not depend combinationally on `tready`.
- `tlast = (beat count == len-1)`. A length-1 frame has `tlast` on every beat.
- `start` while busy is ignored, with no `cfg_err`.
- `load_we` while busy is dropped.
- Length arithmetic: 32-bit compare. Counters are ADDR_W+1 bits, so `len = MEM_DEPTH` is representable.

## Timing
- Reset values: `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `pass_idx=0`, `busy=0`, `done=0`, `cfg_err=0`, state IDLE, FIFO empty.
- `start` high at edge k → `busy` high after edge k → first `tvalid` after edge k+2.
- Throughput is 1 beat/cycle with `tready` held high, including across pass boundaries.
- Total beats per start: `NUM_PASSES*len`. `done` is high for the cycle after the final accept edge.
- `tready` low for N cycles stalls exactly N cycles; the beat order is unchanged.
- Reset mid-stream: every output returns to its reset value after the sampling edge, and the FIFO is flushed. A new `start` is needed.
- Write then `start` on the next cycle: the written data is visible in that transmission.

## Configuration
- `PIXEL_SRC_SOF_EN` defined: adds output `m_axis_tuser` (1 bit), high on beat 0 of every pass, with the same stability rules as `tlast`.
- Not defined: no such port exists, and behaviour is otherwise identical.

## Test plan
- Load 0..15, len=16, NUM_PASSES=2, `tready`=1 → 32 beats 0..15,0..15 on consecutive cycles; `tlast` on beats 15 and 31; `done` one cycle after the final accept.
- Same frame, `tready` toggled pseudo-randomly at 50% → identical data sequence; `tdata`/`tlast` never change while stalled.
- len=1, data 0xA5 → two beats of 0xA5, each with `tlast`=1; `pass_idx` goes 0 then 1.
- `T_TOTAL_PIXELS`=0, then 65537 → a `cfg_err` pulse for each; `busy` stays 0; no `tvalid`.
- Reset asserted on beat 7 of pass 0 → `tvalid`=0 next cycle; a new `start` replays from pixel 0 and pass 0.
- `PIXEL_SRC_SOF_EN` build, len=4 → `tuser`=1 on beats 0 and 4 only.
